// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the pc_fetch slice: word width, default reset
// vector, retire counter width and the fetch FSM state encoding
// (encoding 2'd3 is unreachable and is treated as IDLE).
package pc_fetch_pkg;

    localparam int unsigned WORD_WIDTH = 16;
    localparam int unsigned CNT_WIDTH  = 16;

    localparam logic [WORD_WIDTH-1:0] DEFAULT_RESET_VECTOR = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } fetch_state_e;

endpackage : pc_fetch_pkg

// File: rtl/pc_reg.sv
// Program counter register with synchronous reset to RESET_VECTOR.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   en         : advance the PC this cycle
//   load       : when advancing, take d instead of q+1
//   d          : jump target
//   q          : current PC (wraps modulo 2^WIDTH on increment)
module pc_reg
    import pc_fetch_pkg::*;
#(
    parameter int unsigned           WIDTH        = WORD_WIDTH,
    parameter logic [WIDTH-1:0]      RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    // Next PC: hold, jump or increment (natural wrap)
    always_comb begin
        pc_d = pc_q;
        if (en) begin
            pc_d = load ? d : pc_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign q = pc_q;

endmodule : pc_reg

// File: rtl/pc_fetch.sv
// Program-counter and instruction-fetch stage of the Hack-style CPU.
// Fetches from the instruction ROM with a req/ack handshake and hands each
// instruction to execute with a valid/ready handshake (IDLE -> FETCH -> ISSUE).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   rom_req/rom_addr      : fetch request and address (rom_addr == pc)
//   rom_ack/rom_data      : ROM response, captured in FETCH only
//   instr/instr_valid     : registered instruction and its valid flag
//   instr_ready           : execute retires instr (effective in ISSUE only)
//   load/jump_addr        : on retire, next pc = load ? jump_addr : pc+1
//   pc                    : current program counter
//   retired               : saturating retire count (PC_FETCH_RETIRE_COUNT_EN only)
// Optional feature macro: PC_FETCH_RETIRE_COUNT_EN.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int unsigned      WIDTH        = WORD_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 rom_req,
    output logic [WIDTH-1:0]     rom_addr,
    input  logic                 rom_ack,
    input  logic [WIDTH-1:0]     rom_data,
    output logic [WIDTH-1:0]     instr,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 load,
    input  logic [WIDTH-1:0]     jump_addr,
    output logic [WIDTH-1:0]     pc
`ifdef PC_FETCH_RETIRE_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] retired
`endif
);

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] instr_d;
    logic             rom_req_q;
    logic             rom_req_d;
    logic             instr_valid_q;
    logic             instr_valid_d;
    logic             retire_c;
    logic [WIDTH-1:0] pc_c;

    // Next-state, instruction capture and handshake flags
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        retire_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (rom_ack) begin
                    instr_d = rom_data;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (instr_ready) begin
                    retire_c = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            default: begin
                // Unreachable encoding behaves like IDLE
                state_d = ST_FETCH;
            end
        endcase

        // Flags are registered copies of the next-state decode
        rom_req_d     = (state_d == ST_FETCH);
        instr_valid_d = (state_d == ST_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            instr_q       <= '0;
            rom_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            rom_req_q     <= rom_req_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // PC advances only on a retire; load/jump_addr are ignored otherwise
    pc_reg #(
        .WIDTH        (WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (retire_c),
        .load  (load),
        .d     (jump_addr),
        .q     (pc_c)
    );

`ifdef PC_FETCH_RETIRE_COUNT_EN
    logic [CNT_WIDTH-1:0] retired_q;
    logic [CNT_WIDTH-1:0] retired_d;

    // Saturating retire counter
    always_comb begin
        retired_d = retired_q;
        if (retire_c && (retired_q != {CNT_WIDTH{1'b1}})) begin
            retired_d = retired_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`endif

    assign rom_req     = rom_req_q;
    assign rom_addr    = pc_c;
    assign pc          = pc_c;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;

endmodule : pc_fetch

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed stimulus with a small ROM responder, a
// transaction-level reference model checked every cycle on the falling
// edge, and hand-computed literal checks at the key points.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        rom_req;
    logic [15:0] rom_addr;
    logic        rom_ack;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        load;
    logic [15:0] jump_addr;
    logic [15:0] pc;
`ifdef PC_FETCH_RETIRE_COUNT_EN
    logic [15:0] retired;
`endif

    int checks = 0;
    int errors = 0;

    // ROM responder controls
    bit rom_en  = 1'b1;
    int ws      = 0;
    int wait_cnt = 0;

    always #5 clk = ~clk;

    pc_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_ack     (rom_ack),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .load        (load),
        .jump_addr   (jump_addr),
        .pc          (pc)
`ifdef PC_FETCH_RETIRE_COUNT_EN
        ,
        .retired     (retired)
`endif
    );

    // ROM contents: address 0 holds 0x1234, others {~a[7:0], a[7:0]}
    function automatic logic [15:0] rom_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h1234;
        return {~a[7:0], a[7:0]};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Transaction view: the stage is either waiting to start, waiting on
    // the ROM for the word at m_pc, or holding a word for execute.
    localparam int M_START = 0;
    localparam int M_WAIT  = 1;
    localparam int M_HOLD  = 2;

    int          m_phase;
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    int          m_retires;
    bit          m_live = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase   <= M_START;
            m_pc      <= 16'h0000;
            m_instr   <= 16'h0000;
            m_retires <= 0;
            m_live    <= 1'b1;
        end else if (m_live) begin
            if (m_phase == M_START) begin
                m_phase <= M_WAIT;
            end else if (m_phase == M_WAIT) begin
                if (rom_ack) begin
                    m_instr <= rom_data;
                    m_phase <= M_HOLD;
                end
            end else if (instr_ready) begin
                m_retires <= (m_retires < 65535) ? m_retires + 1 : 65535;
                m_pc      <= load ? jump_addr : 16'((int'(m_pc) + 1) % 65536);
                m_phase   <= M_WAIT;
            end
        end
    end

    // Compare every cycle once the model has seen reset
    always @(negedge clk) begin
        if (m_live) begin
            chk("model_rom_req", 16'(rom_req), 16'(m_phase == M_WAIT));
            chk("model_instr_valid", 16'(instr_valid), 16'(m_phase == M_HOLD));
            chk("model_pc", pc, m_pc);
            chk("model_rom_addr", rom_addr, m_pc);
            chk("model_instr", instr, m_instr);
`ifdef PC_FETCH_RETIRE_COUNT_EN
            chk("model_retired", retired, 16'(m_retires));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    // Advance one cycle and let the ROM respond after ws wait cycles
    task automatic tick();
        @(posedge clk);
        #1;
        if (rom_req && rom_en) begin
            rom_ack  = (wait_cnt >= ws);
            rom_data = rom_ack ? rom_word(rom_addr) : 16'h0BAD;
            wait_cnt++;
        end else begin
            rom_ack  = 1'b0;
            rom_data = 16'h0BAD;
            wait_cnt = 0;
        end
    endtask

    task automatic wait_valid();
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_valid_timeout actual=0 expected=1 t=%0t", $time);
        end
    endtask

    task automatic retire(input logic ld, input logic [15:0] ja);
        instr_ready = 1'b1;
        load        = ld;
        jump_addr   = ja;
        tick();
        instr_ready = 1'b0;
        load        = 1'b0;
        jump_addr   = 16'h0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        rom_ack     = 1'b0;
        rom_data    = 16'h0000;
        instr_ready = 1'b0;
        load        = 1'b0;
        jump_addr   = 16'h0000;

        // Reset held three cycles, then released
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_rom_req", 16'(rom_req), 16'h0000);
        end
        reset = 1'b0;
        chk("reset_pc", pc, 16'h0000);
        chk("reset_instr", instr, 16'h0000);
        chk("reset_valid", 16'(instr_valid), 16'h0000);
        chk("post_reset_idle_req", 16'(rom_req), 16'h0000);
        tick();
        chk("first_fetch_req", 16'(rom_req), 16'h0001);
        chk("first_fetch_addr", rom_addr, 16'h0000);

        // Zero-wait ROM, execute always accepting
        tick();
        chk("zw_valid", 16'(instr_valid), 16'h0001);
        chk("zw_instr", instr, 16'h1234);
        instr_ready = 1'b1;
        tick();
        chk("zw_next_addr", rom_addr, 16'h0001);
        chk("zw_next_req", 16'(rom_req), 16'h0001);
        tick();
        chk("zw_valid2", 16'(instr_valid), 16'h0001);
        tick();
        chk("zw_two_cycle_pc", pc, 16'h0002);
        instr_ready = 1'b0;
        tick();
        chk("zw_instr2", instr, 16'hFD02);

        // Three ROM wait states, then a four-cycle execute stall
        ws = 3;
        retire(1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            chk("ws_req_held", 16'(rom_req), 16'h0001);
            chk("ws_no_valid", 16'(instr_valid), 16'h0000);
            tick();
        end
        chk("ws_req_ack_cycle", 16'(rom_req), 16'h0001);
        chk("ws_ack_now", 16'(rom_ack), 16'h0001);
        tick();
        chk("ws_valid", 16'(instr_valid), 16'h0001);
        for (int i = 0; i < 4; i++) begin
            // Stray ack while holding must be ignored
            rom_ack  = 1'b1;
            rom_data = 16'hDEAD;
            tick();
            chk("stall_instr", instr, 16'hFC03);
            chk("stall_pc", pc, 16'h0003);
            chk("stall_valid", 16'(instr_valid), 16'h0001);
        end
        retire(1'b0, 16'h0000);
        chk("stall_single_retire", pc, 16'h0004);

        // Jump on retire, then load while nothing is valid
        ws = 0;
        wait_valid();
        rom_en = 1'b0;
        retire(1'b1, 16'h7FF0);
        chk("jump_addr", rom_addr, 16'h7FF0);
        instr_ready = 1'b1;
        load        = 1'b1;
        jump_addr   = 16'h1234;
        tick();
        tick();
        chk("ignored_load_addr", rom_addr, 16'h7FF0);
        chk("ignored_load_valid", 16'(instr_valid), 16'h0000);
        instr_ready = 1'b0;
        load        = 1'b0;
        jump_addr   = 16'h0000;
        rom_en      = 1'b1;

        // PC wrap from 0xFFFF
        wait_valid();
        retire(1'b1, 16'hFFFF);
        chk("to_ffff", rom_addr, 16'hFFFF);
        wait_valid();
        chk("instr_ffff", instr, 16'h00FF);
        retire(1'b0, 16'h0000);
        chk("wrap_addr", rom_addr, 16'h0000);

        // Reset coincident with ack discards the word
        wait_valid();
        rom_en = 1'b0;
        retire(1'b0, 16'h0000);
        chk("pre_reset_pc", pc, 16'h0001);
        tick();
        reset    = 1'b1;
        rom_ack  = 1'b1;
        rom_data = 16'hBEEF;
        tick();
        chk("rst_ack_instr", instr, 16'h0000);
        chk("rst_ack_pc", pc, 16'h0000);
        chk("rst_ack_valid", 16'(instr_valid), 16'h0000);
        chk("rst_ack_req", 16'(rom_req), 16'h0000);
        reset   = 1'b0;
        rom_ack = 1'b0;
        rom_en  = 1'b1;
        tick();
        chk("rst_ack_idle_valid", 16'(instr_valid), 16'h0000);

        // Reset while holding an instruction
        wait_valid();
        reset = 1'b1;
        tick();
        chk("rst_issue_valid", 16'(instr_valid), 16'h0000);
        reset = 1'b0;
        tick();

        // Five retires from reset
        for (int i = 0; i < 5; i++) begin
            wait_valid();
            retire(1'b0, 16'h0000);
        end
        chk("five_retire_pc", pc, 16'h0005);
`ifdef PC_FETCH_RETIRE_COUNT_EN
        chk("five_retired", retired, 16'h0005);
        reset = 1'b1;
        tick();
        chk("retired_reset", retired, 16'h0000);
        reset = 1'b0;
`endif
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pc_fetch
